// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encoding and PC helpers for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

    // sll $0,$0,0: a bubble that can only ever write $0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] PC_INC            = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bundle: imem port, hazard/redirect inputs, IF/ID outputs
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        misalign_err;

    modport master (
        input  imem_rdata,
        input  stall,
        input  flush,
        input  branch_taken,
        input  branch_target,
        input  jump_en,
        input  jump_target,
        output imem_addr,
        output pc,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid,
        output opcode,
        output func,
        output misalign_err
    );

    modport slave (
        output imem_rdata,
        output stall,
        output flush,
        output branch_taken,
        output branch_target,
        output jump_en,
        output jump_target,
        input  imem_addr,
        input  pc,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid,
        input  opcode,
        input  func,
        input  misalign_err
    );

endinterface

// File: rtl/fetch_stage_pc_unit.sv
// rtl/fetch_stage_pc_unit.sv - PC register, next-PC select and sticky redirect alignment check
module fetch_stage_pc_unit
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pc_o,
    output logic        redirect_o,
    output logic        misalign_err_o
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;

    // Branch wins over jr when both arrive together; redirects ignore stall.
    always_comb begin
        target     = branch_taken_i ? branch_target_i : jump_target_i;
        redirect_o = run_i & (branch_taken_i | jump_en_i);
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect_o) begin
            pc_d = align_word(target);
            if (is_misaligned(target)) begin
                misalign_d = 1'b1;
            end
        end else if (run_i && !stall_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o           = pc_q;
    assign misalign_err_o = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM and IF/ID pipeline register feeding decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_e state_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc4_q;
    logic         valid_q;
    logic [31:0]  pc;
    logic         redirect;
    logic         misalign_err;
    logic         run;

    assign run = (state_q != ST_BOOT);

    fetch_stage_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk             (clk),
        .rst             (rst),
        .run_i           (run),
        .stall_i         (bus.stall),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .jump_en_i       (bus.jump_en),
        .jump_target_i   (bus.jump_target),
        .pc_o            (pc),
        .redirect_o      (redirect),
        .misalign_err_o  (misalign_err)
    );

    // Every invalid slot carries NOP_INSTR so downstream writes can only hit $0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    instr_q <= NOP_INSTR;
                    pc4_q   <= 32'd0;
                    valid_q <= 1'b0;
                    state_q <= ST_RUN;
                end
                ST_RUN, ST_REDIRECT: begin
                    if (redirect) begin
                        instr_q <= NOP_INSTR;
                        pc4_q   <= 32'd0;
                        valid_q <= 1'b0;
                        state_q <= ST_REDIRECT;
                    end else begin
                        state_q <= ST_RUN;
                        if (bus.flush) begin
                            instr_q <= NOP_INSTR;
                            pc4_q   <= 32'd0;
                            valid_q <= 1'b0;
                        end else if (!bus.stall) begin
                            instr_q <= bus.imem_rdata;
                            pc4_q   <= pc + PC_INC;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    instr_q <= NOP_INSTR;
                    pc4_q   <= 32'd0;
                    valid_q <= 1'b0;
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.pc           = pc;
    assign bus.imem_addr    = pc;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_pc4    = pc4_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.opcode       = instr_q[31:26];
    assign bus.func         = instr_q[5:0];
    assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   sb[$];
    int     checks;
    int     errors;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc",           bus.pc,           e.pc);
            chk("imem_addr",    bus.imem_addr,    e.pc);
            chk("if_id_instr",  bus.if_id_instr,  e.instr);
            chk("if_id_pc4",    bus.if_id_pc4,    e.pc4);
            chk("if_id_valid",  {31'd0, bus.if_id_valid},  {31'd0, e.valid});
            chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.mis});
            chk("opcode",       {26'd0, bus.opcode}, {26'd0, e.instr[31:26]});
            chk("func",         {26'd0, bus.func},   {26'd0, e.instr[5:0]});
        end
    end

    task automatic step(input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] epc4, input logic ev, input logic em);
        exp_t e;
        rst               = r;
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.jump_en       = j;
        bus.jump_target   = jt;
        e.pc = epc; e.instr = einstr; e.pc4 = epc4; e.valid = ev; e.mis = em;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic norm(input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] epc4, input logic em);
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, epc, einstr, epc4, 1'b1, em);
    endtask

    task automatic bubble(input logic s, input logic f, input logic b, input logic [31:0] bt,
                          input logic j, input logic [31:0] jt, input logic [31:0] epc,
                          input logic em);
        step(0, s, f, b, bt, j, jt, epc, 32'h0, 32'h0, 1'b0, em);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // reset, then BOOT cycle holds pc and presents a bubble
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bubble(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
        norm(32'h4,  32'hA5A5_0000, 32'h4,  1'b0);
        norm(32'h8,  32'hA5A5_0004, 32'h8,  1'b0);
        norm(32'hC,  32'hA5A5_0008, 32'hC,  1'b0);
        norm(32'h10, 32'hA5A5_000C, 32'h10, 1'b0);
        // three-cycle stall at pc=0x10
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h10, 32'hA5A5_000C, 32'h10, 1'b1, 1'b0);
        norm(32'h14, 32'hA5A5_0010, 32'h14, 1'b0);
        norm(32'h18, 32'hA5A5_0014, 32'h18, 1'b0);
        norm(32'h1C, 32'hA5A5_0018, 32'h1C, 1'b0);
        norm(32'h20, 32'hA5A5_001C, 32'h20, 1'b0);
        // flush alone at 0x20, then flush+stall at 0x28
        bubble(0, 1, 0, 32'h0, 0, 32'h0, 32'h24, 1'b0);
        norm(32'h28, 32'hA5A5_0024, 32'h28, 1'b0);
        bubble(1, 1, 0, 32'h0, 0, 32'h0, 32'h28, 1'b0);
        norm(32'h2C, 32'hA5A5_0028, 32'h2C, 1'b0);
        // branch + jump + stall together: branch wins
        bubble(1, 0, 1, 32'h100, 1, 32'h200, 32'h100, 1'b0);
        norm(32'h104, 32'hA5A5_0100, 32'h104, 1'b0);
        norm(32'h108, 32'hA5A5_0104, 32'h108, 1'b0);
        // misaligned jr target, sticky flag
        bubble(0, 0, 0, 32'h0, 1, 32'h0000_0042, 32'h40, 1'b1);
        norm(32'h44, 32'hA5A5_0040, 32'h44, 1'b1);
        bubble(0, 0, 1, 32'h80, 0, 32'h0, 32'h80, 1'b1);
        bubble(0, 0, 0, 32'h0, 1, 32'h300, 32'h300, 1'b1);
        bubble(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        // reset while in REDIRECT at pc=0xFFFF_FFFC
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bubble(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1'b0);
        norm(32'h4, 32'hA5A5_0000, 32'h4, 1'b0);
        // wrap from 0xFFFF_FFFC to 0 without reset
        bubble(0, 0, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
        norm(32'hFFFF_FFFC, 32'h5A5A_FFF8, 32'hFFFF_FFFC, 1'b0);
        norm(32'h0,         32'h5A5A_FFFC, 32'h0,         1'b0);
        norm(32'h4,         32'hA5A5_0000, 32'h4,         1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
